// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: shared state type and header/counter constants for the tx frame packer
package tx_frame_pkg;
    typedef enum logic [2:0] {IDLE, GAP, HDR, PAY, DROP} state_e;
    localparam int HDR_LEN_TYPE = 1;
    localparam int HDR_LEN_FULL = 3;
    localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/tx_frame_packer_if.sv
// tx_frame_packer_if: byte source, framed-byte sink and backpressure signals of the packer
interface tx_frame_packer_if;
    logic [7:0] i_data_in;
    logic       i_data_valid;
    logic [7:0] i_para_type;
    logic       i_dst_ready;
    logic [7:0] o_data_out;
    logic       o_data_valid;
    logic       o_sof;
    logic       o_eof;
    modport slave (
        input  i_data_in, i_data_valid, i_para_type, i_dst_ready,
        output o_data_out, o_data_valid, o_sof, o_eof
    );
    modport master (
        output i_data_in, i_data_valid, i_para_type, i_dst_ready,
        input  o_data_out, o_data_valid, o_sof, o_eof
    );
endinterface

// File: rtl/tx_frame_sync_fifo.sv
// tx_frame_sync_fifo: single-clock first-word-fall-through byte FIFO with flush
module tx_frame_sync_fifo #(
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_wr, do_rd;
    assign full_o    = cnt_q == CW'(DEPTH);
    assign empty_o   = cnt_q == '0;
    assign count_o   = cnt_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    // storage array, written only when there is room
    always_ff @(posedge clk_i)
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    // pointers and occupancy; flush empties the FIFO in one cycle
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
        end
endmodule

// File: rtl/tx_frame_packer.sv
// tx_frame_packer: buffers one byte burst and emits it as a type/length-headed frame
module tx_frame_packer
    import tx_frame_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int GAP_CYC = 16,
    parameter bit LEN_EN  = 1'b1
) (
    input  logic                  i_clk163m84,
    input  logic                  i_rst_n,
    tx_frame_packer_if.slave      bus,
    output logic                  o_busy,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] HDR_LAST = 2'(LEN_EN ? HDR_LEN_FULL - 1 : HDR_LEN_TYPE - 1);

    state_e                state_q;
    logic [7:0]            din_q, type_q, data_q, gap_q;
    logic                  dv_q, own_q, valid_q, sof_q, eof_q, ovf_q;
    logic [12:0]           wr_len_q, len_q, pay_q;
    logic [1:0]            hdr_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  burst_end, wr_en, ovf_d, accept, hdr_done, pay_next, drop_done, fin, rd_en;
    logic [12:0]           wr_len_d;
    logic [15:0]           len16;
    logic [1:0]            drop_inc;
    logic [DROP_CNT_W:0]   drop_sum;
    logic                  fifo_full, fifo_empty;
    logic [7:0]            fifo_data;
    logic [CW-1:0]         fifo_cnt;

    // the last byte of a burst is written in the same cycle its end is seen, so
    // the latched length and overflow flag must include that cycle's write
    assign burst_end = dv_q && !bus.i_data_valid;
    assign wr_en     = dv_q && own_q && !fifo_full;
    assign ovf_d     = ovf_q || (dv_q && own_q && fifo_full);
    assign wr_len_d  = wr_len_q + 13'(wr_en);
    assign len16     = {3'b0, len_q};
    assign accept    = valid_q && bus.i_dst_ready;
    assign hdr_done  = state_q == HDR && accept && hdr_q == HDR_LAST;
    assign pay_next  = state_q == PAY && accept && !eof_q;
    assign drop_done = state_q == DROP && fifo_cnt <= CW'(1);
    assign fin       = (state_q == PAY && accept && eof_q) || drop_done;
    assign rd_en     = hdr_done || pay_next || (state_q == DROP && !fifo_empty);
    assign drop_inc  = 2'(drop_done) + 2'(burst_end && !own_q);
    assign drop_sum  = {1'b0, drop_q} + (DROP_CNT_W + 1)'(drop_inc);

    assign bus.o_data_out   = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_sof        = sof_q;
    assign bus.o_eof        = eof_q;
    assign o_busy           = state_q != IDLE;
    assign o_drop_cnt       = drop_q;

    tx_frame_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (i_clk163m84),
        .rst_ni    (i_rst_n),
        .flush_i   (fin),
        .wr_en_i   (wr_en),
        .wr_data_i (din_q),
        .rd_en_i   (rd_en),
        .rd_data_o (fifo_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    // input register stage; a burst is owned only if its first byte arrives in IDLE
    always_ff @(posedge i_clk163m84 or negedge i_rst_n)
        if (!i_rst_n) begin
            din_q <= '0;
            dv_q  <= 1'b0;
            own_q <= 1'b0;
        end else begin
            din_q <= bus.i_data_in;
            dv_q  <= bus.i_data_valid;
            if (bus.i_data_valid && !dv_q) own_q <= state_q == IDLE;
        end

    // frame sequencer with registered output byte, markers and drop counter
    always_ff @(posedge i_clk163m84 or negedge i_rst_n)
        if (!i_rst_n) begin
            state_q  <= IDLE;
            type_q   <= '0;
            len_q    <= '0;
            wr_len_q <= '0;
            ovf_q    <= 1'b0;
            gap_q    <= '0;
            hdr_q    <= '0;
            pay_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_len_q <= wr_len_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
            case (state_q)
                IDLE: if (burst_end && own_q) begin
                    type_q  <= bus.i_para_type;
                    len_q   <= wr_len_d;
                    gap_q   <= '0;
                    state_q <= ovf_d ? DROP : GAP;
                end
                GAP: if (gap_q == 8'(GAP_CYC)) begin
                    state_q <= HDR;
                    hdr_q   <= '0;
                    data_q  <= type_q;
                    valid_q <= 1'b1;
                    sof_q   <= 1'b1;
                end else begin
                    gap_q <= gap_q + 8'd1;
                end
                HDR: if (hdr_done) begin
                    state_q <= PAY;
                    data_q  <= fifo_data;
                    sof_q   <= 1'b0;
                    eof_q   <= len_q == 13'd1;
                    pay_q   <= 13'd1;
                end else if (accept) begin
                    hdr_q  <= hdr_q + 2'd1;
                    sof_q  <= 1'b0;
                    data_q <= hdr_q == 2'd0 ? len16[15:8] : len16[7:0];
                end
                PAY: if (pay_next) begin
                    data_q <= fifo_data;
                    pay_q  <= pay_q + 13'd1;
                    eof_q  <= pay_q + 13'd1 == len_q;
                end else if (accept) begin
                    state_q <= IDLE;
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    eof_q   <= 1'b0;
                end
                DROP: if (drop_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (fin) begin
                wr_len_q <= '0;
                ovf_q    <= 1'b0;
            end
        end
endmodule

// File: tb/tb_tx_frame_packer.sv
// tb_tx_frame_packer: scoreboard bench for the tx frame packer (length and type-only variants)
module tb_tx_frame_packer;
    localparam int DEPTH = 16;
    localparam int GAP_A = 4;
    localparam int GAP_B = 3;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic [7:0]  ptype = '0;
    logic        dv_a = 1'b0;
    logic        dv_b = 1'b0;
    logic        rdy_a = 1'b1;
    logic        tog_en = 1'b0;
    logic        busy_a, busy_b;
    logic [15:0] drop_a, drop_b;
    logic [7:0]  pl[$];
    exp_t        qa[$];
    exp_t        qb[$];
    int          total = 0;
    int          bad = 0;

    tx_frame_packer_if ia ();
    tx_frame_packer_if ib ();

    assign ia.i_data_in    = din;
    assign ia.i_data_valid = dv_a;
    assign ia.i_para_type  = ptype;
    assign ia.i_dst_ready  = rdy_a;
    assign ib.i_data_in    = din;
    assign ib.i_data_valid = dv_b;
    assign ib.i_para_type  = ptype;
    assign ib.i_dst_ready  = 1'b1;

    tx_frame_packer #(.DEPTH(DEPTH), .GAP_CYC(GAP_A), .LEN_EN(1'b1)) dut_a (
        .i_clk163m84 (clk),
        .i_rst_n     (rst_n),
        .bus         (ia),
        .o_busy      (busy_a),
        .o_drop_cnt  (drop_a)
    );

    tx_frame_packer #(.DEPTH(DEPTH), .GAP_CYC(GAP_B), .LEN_EN(1'b0)) dut_b (
        .i_clk163m84 (clk),
        .i_rst_n     (rst_n),
        .bus         (ib),
        .o_busy      (busy_b),
        .o_drop_cnt  (drop_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit to_b, input exp_t e);
        if (to_b) qb.push_back(e);
        else qa.push_back(e);
    endtask

    // expected frame built from the payload queue: type, optional length, payload
    task automatic expect_frame(input bit to_b, input logic [7:0] typ, input bit len_en);
        push(to_b, {typ, 1'b1, 1'b0});
        if (len_en) begin
            push(to_b, {8'(pl.size() >> 8), 1'b0, 1'b0});
            push(to_b, {8'(pl.size()), 1'b0, 1'b0});
        end
        foreach (pl[i]) push(to_b, {pl[i], 1'b0, i == pl.size() - 1});
    endtask

    task automatic send(input bit to_b, input logic [7:0] typ);
        ptype = typ;
        foreach (pl[i]) begin
            @(posedge clk); #1;
            din = pl[i];
            if (to_b) dv_b = 1'b1;
            else dv_a = 1'b1;
        end
        @(posedge clk); #1;
        dv_a = 1'b0;
        dv_b = 1'b0;
        din = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        @(negedge clk);
        chk("rst_a", 32'({ia.o_data_out, ia.o_data_valid, ia.o_sof, ia.o_eof, busy_a, drop_a}), 0);
        chk("rst_b", 32'({ib.o_data_out, ib.o_data_valid, ib.o_sof, ib.o_eof, busy_b, drop_b}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        repeat (3) @(posedge clk);
        while ((qa.size() != 0 || qb.size() != 0 || busy_a || busy_b) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(qa.size() + qb.size()), 0);
        chk({tag, "_busy"}, 32'({busy_a, busy_b}), 0);
    endtask

    task automatic wait_sof(input string tag);
        int n = 0;
        while (!ia.o_sof && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(ia.o_sof), 1);
    endtask

    // ready pattern 1,0,0,1 while toggling is enabled
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            rdy_a = !tog_en || ph == 0 || ph == 3;
            ph = (ph + 1) % 4;
        end
    end

    // monitor A: scoreboard, hold-under-backpressure, idle-zero and busy-fall checks
    initial begin
        exp_t prev;
        logic hold, was_eof;
        hold = 1'b0;
        was_eof = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                was_eof = 1'b0;
            end else begin
                if (was_eof) chk("a_busy_fall", 32'(busy_a), 0);
                was_eof = 1'b0;
                if (hold) chk("a_hold", 32'({ia.o_data_valid, ia.o_data_out, ia.o_sof, ia.o_eof}), 32'({1'b1, prev}));
                hold = 1'b0;
                if (!ia.o_data_valid) chk("a_idle_out", 32'(ia.o_data_out), 0);
                else if (!rdy_a) begin
                    hold = 1'b1;
                    prev = {ia.o_data_out, ia.o_sof, ia.o_eof};
                end else if (qa.size() == 0) chk("a_unexp", 32'(ia.o_data_valid), 0);
                else begin
                    chk("a_data", 32'({ia.o_data_out, ia.o_sof, ia.o_eof}), 32'(qa.pop_front()));
                    if (ia.o_eof) begin
                        chk("a_busy_eof", 32'(busy_a), 1);
                        was_eof = 1'b1;
                    end
                end
            end
        end
    end

    // monitor B: scoreboard and idle-zero checks (ready tied high)
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (!ib.o_data_valid) chk("b_idle_out", 32'(ib.o_data_out), 0);
            else if (qb.size() == 0) chk("b_unexp", 32'(ib.o_data_valid), 0);
            else chk("b_data", 32'({ib.o_data_out, ib.o_sof, ib.o_eof}), 32'(qb.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        do_reset();
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_frame(1'b0, 8'h5A, 1'b1);
        send(1'b0, 8'h5A);
        lat = 0;
        for (int c = 1; c <= 64 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (ia.o_data_valid) lat = c;
        end
        chk("t1_latency", 32'(lat), 32'(GAP_A + 2));
        drain("t1_drain");
        tog_en = 1'b1;
        expect_frame(1'b0, 8'h5A, 1'b1);
        send(1'b0, 8'h5A);
        drain("t2_drain");
        tog_en = 1'b0;
        do_reset();
        pl.delete();
        for (int i = 0; i < DEPTH + 1; i++) pl.push_back(8'(i * 3 + 1));
        send(1'b0, 8'hEE);
        drain("t3_drop_drain");
        chk("t3_drop_cnt", 32'(drop_a), 1);
        pl = '{8'hB0, 8'hB1};
        expect_frame(1'b0, 8'h01, 1'b1);
        send(1'b0, 8'h01);
        drain("t3_drain");
        chk("t3_drop_after", 32'(drop_a), 1);
        do_reset();
        pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        expect_frame(1'b0, 8'h33, 1'b1);
        send(1'b0, 8'h33);
        wait_sof("t4_sof");
        repeat (3) @(posedge clk);
        pl = '{8'hC1, 8'hC2, 8'hC3};
        send(1'b0, 8'h99);
        drain("t4_drain");
        chk("t4_drop_cnt", 32'(drop_a), 1);
        do_reset();
        pl = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        expect_frame(1'b0, 8'h44, 1'b1);
        send(1'b0, 8'h44);
        wait_sof("t5_sof");
        repeat (4) @(posedge clk);
        do_reset();
        pl = '{8'hAB};
        expect_frame(1'b0, 8'h07, 1'b1);
        send(1'b0, 8'h07);
        drain("t5_drain");
        chk("t5_drop_cnt", 32'(drop_a), 0);
        pl.delete();
        for (int i = 0; i < DEPTH; i++) pl.push_back(8'(i * 7 + 3));
        expect_frame(1'b1, 8'hC3, 1'b0);
        send(1'b1, 8'hC3);
        drain("t6_drain");
        chk("t6_drop_cnt", 32'(drop_b), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
